freq_display: RTL and testbench
===============================

FREQ_DISPLAY -- requirements
Module: freq_display

Interface
REQ-001 Clocking and reset SHALL be: one clock; reset is asynchronous and active-low.
REQ-002 Parameter CNT_W, default 14, width of binary count input; legal range 4..20.
REQ-003 Parameter REFRESH_DIV, default 100000, CLK cycles per digit slot (1 kHz digit rate at 100 MHz); legal ≥2.
REQ-004 CLK  input  1  system clock, rising edge.
REQ-005 RST_N  input  1  asynchronous active-low reset.
REQ-006 count  input  CNT_W  binary frequency measurement from upstream freq_counter.
REQ-007 count_valid  input  1  single-cycle strobe; count is valid this cycle.
REQ-008 busy  output  1  high while a conversion is in progress.
REQ-009 bcd  output  16  four BCD digits of last completed conversion; [3:0] = units.
REQ-010 overflow  output  1  last converted count exceeded 9999.
REQ-011 an  output  4  digit enables, active-low, one-hot; an[0] = units.
REQ-012 seg  output  7  segments {g,f,e,d,c,b,a}, active-low.

Function
REQ-013 Converter FSM SHALL have states IDLE, SHIFT, DONE.
REQ-014 IDLE: count_valid sampled high at edge k -> latch count, clear scratch BCD, iteration counter = 0, busy = 1, go to SHIFT.
REQ-015 SHIFT: each cycle add 3 to every scratch nibble ≥5, then shift {scratch, binary} left one bit; after exactly CNT_W shifts (edges k+1..k+CNT_W) go to DONE.
REQ-016 DONE: at edge k+CNT_W+1 load bcd and overflow, busy = 0, return to IDLE; total latency CNT_W+1 cycles from strobe edge to bcd update.
REQ-017 Latched count > 9999 SHALL set overflow = 1 and load bcd = 16'h9999; otherwise overflow = 0 and bcd = exact conversion.
REQ-018 count_valid while busy = 1 (including the DONE cycle) SHALL be ignored; no queuing.
REQ-019 bcd and overflow SHALL hold their values between conversions.
REQ-020 Refresh counter SHALL count 0..REFRESH_DIV-1 and wrap; at wrap the digit index advances 0->1->2->3->0.
REQ-021 an and seg SHALL be registered; one cycle after the index changes they reflect the new digit and current bcd.
REQ-022 Segment map (active-low): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000; nibbles A-F SHALL display blank (1111111).
REQ-023 When overflow = 1, all four digits SHALL display dash (seg = 0111111).

Reset
REQ-024 RST_N low SHALL immediately force: FSM IDLE, busy 0, bcd 0, overflow 0, refresh counter 0, digit index 0, an 1111, seg 1111111.
REQ-025 Reset asserted mid-conversion SHALL abort it; bcd stays 0 and no DONE update occurs after release.
REQ-026 From the first clock edge after RST_N rises, an = 1110 and seg shows digit 0 of bcd.

Configuration
REQ-027 Macro FREQ_DISPLAY_LZB_EN defined: leading-zero blanking; digits 3..1 show blank (an bit stays asserted, seg 1111111) while they and every higher digit are zero; digit 0 never blanked; blanking suppressed when overflow = 1.
REQ-028 Macro FREQ_DISPLAY_LZB_EN undefined: all four digits always displayed, zeros included.

Verification
REQ-029 Reset then count=1234, one-cycle count_valid -> busy high 15 cycles (CNT_W=14), bcd=16'h1234 at edge k+15, overflow 0.
REQ-030 count=10000 -> bcd=16'h9999, overflow 1, all digits show 0111111.
REQ-031 Second count_valid (count=5678) 3 cycles after first (1234) -> ignored; bcd=16'h1234.
REQ-032 REFRESH_DIV=4, bcd=16'h0042 -> an sequence 1110,1101,1011,0111 every 4 cycles; seg 0011001,0100100,1000000,1000000 without macro; digits 3,2 blank (1111111) with FREQ_DISPLAY_LZB_EN.
REQ-033 RST_N pulsed low at SHIFT iteration 5 -> busy 0, bcd 0 immediately, no later update; next count=9 converts to 16'h0009.
REQ-034 count=0 and count=9999 -> bcd 16'h0000 and 16'h9999, overflow 0.

Source files
------------

// File: rtl/freq_display.sv
// freq_display: binary-to-BCD converter (shift-and-add-3) feeding a
// four-digit multiplexed seven-segment driver.
// Optional feature: define FREQ_DISPLAY_LZB_EN for leading-zero blanking.
module freq_display #(
    parameter int CNT_W       = 14,
    parameter int REFRESH_DIV = 100000
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [CNT_W-1:0] count,
    input  logic             count_valid,
    output logic             busy,
    output logic [15:0]      bcd,
    output logic             overflow,
    output logic [3:0]       an,
    output logic [6:0]       seg
);

    // Scratch holds every decimal digit the widest count can produce,
    // never fewer than the four digits that reach the bcd output.
    localparam int ND     = ((CNT_W + 2) / 3 > 4) ? (CNT_W + 2) / 3 : 4;
    localparam int SCR_W  = 4 * ND;
    localparam int ITER_W = $clog2(CNT_W);
    localparam int REF_W  = $clog2(REFRESH_DIV);

    localparam logic [ITER_W-1:0] LAST_ITER = ITER_W'(CNT_W - 1);
    localparam logic [REF_W-1:0]  LAST_REF  = REF_W'(REFRESH_DIV - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ITER_W-1:0] iter;
    logic              ovf_p0;
    logic [CNT_W-1:0]  bin_p0;
    logic [SCR_W-1:0]  scr_p0;
    logic [SCR_W-1:0]  scr_adj;

    logic [REF_W-1:0]  refcnt;
    logic [1:0]        dsel;
    logic [3:0]        nib;
    logic              blank;
    logic [3:0]        an_nxt;
    logic [6:0]        seg_nxt;

    // Counts above four decimal digits cannot be shown.
    function automatic logic is_over(input logic [CNT_W-1:0] v);
        return (32'(v) > 32'd9999);
    endfunction

    // Saturate an out-of-range conversion to the largest displayable value.
    function automatic logic [15:0] sat_bcd(input logic [15:0] raw, input logic ovf);
        return ovf ? 16'h9999 : raw;
    endfunction

    // Active-low {g,f,e,d,c,b,a}; non-decimal nibbles are blank.
    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    // Converter next-state: one shift per cycle, then a single DONE cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (count_valid) state_nxt = SHIFT;
            SHIFT:   if (iter == LAST_ITER) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Add-3 correction on every scratch digit that would overflow on doubling.
    always_comb begin
        scr_adj = scr_p0;
        for (int i = 0; i < ND; i++) begin
            if (scr_p0[4*i +: 4] >= 4'd5)
                scr_adj[4*i +: 4] = scr_p0[4*i +: 4] + 4'd3;
        end
    end

    // Converter control and result registers; reset aborts any conversion.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state    <= IDLE;
            busy     <= 1'b0;
            iter     <= '0;
            ovf_p0   <= 1'b0;
            bcd      <= 16'h0000;
            overflow <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt != IDLE);
            case (state)
                IDLE: begin
                    if (count_valid) begin
                        iter   <= '0;
                        ovf_p0 <= is_over(count);
                    end
                end
                SHIFT: iter <= iter + ITER_W'(1);
                DONE: begin
                    bcd      <= sat_bcd(scr_p0[15:0], ovf_p0);
                    overflow <= ovf_p0;
                end
                default: ;
            endcase
        end
    end

    // Conversion datapath: {scratch, binary} treated as one left-shifting register.
    always_ff @(posedge CLK) begin
        if (state == IDLE && count_valid) begin
            bin_p0 <= count;
            scr_p0 <= '0;
        end else if (state == SHIFT) begin
            {scr_p0, bin_p0} <= {scr_adj, bin_p0} << 1;
        end
    end

    // Refresh divider; each wrap moves the scan to the next digit.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            refcnt <= '0;
            dsel   <= 2'd0;
        end else if (refcnt == LAST_REF) begin
            refcnt <= '0;
            dsel   <= dsel + 2'd1;
        end else begin
            refcnt <= refcnt + REF_W'(1);
        end
    end

`ifdef FREQ_DISPLAY_LZB_EN
    // A digit is blank while it and every higher digit are zero; units never blank.
    always_comb begin
        blank = 1'b0;
        case (dsel)
            2'd3:    blank = (bcd[15:12] == 4'd0);
            2'd2:    blank = (bcd[15:8] == 8'd0);
            2'd1:    blank = (bcd[15:4] == 12'd0);
            default: blank = 1'b0;
        endcase
        if (overflow) blank = 1'b0;
    end
`else
    // Every digit shown, leading zeros included.
    assign blank = 1'b0;
`endif

    // Pick the scanned digit and its segment pattern; overflow shows dashes.
    always_comb begin
        nib    = bcd[{dsel, 2'b00} +: 4];
        an_nxt = ~(4'b0001 << dsel);
        if (overflow)
            seg_nxt = 7'b0111111;
        else if (blank)
            seg_nxt = 7'b1111111;
        else
            seg_nxt = seg_decode(nib);
    end

    // Registered display drive; dark while in reset.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            an  <= 4'b1111;
            seg <= 7'b1111111;
        end else begin
            an  <= an_nxt;
            seg <= seg_nxt;
        end
    end

endmodule

// File: tb/tb_freq_display.sv
// Self-checking bench for freq_display: per-cycle reference model plus
// directed literal checks and randomized conversion traffic.
module tb_freq_display;

    localparam int CNT_W = 14;
    localparam int DIV   = 4;
`ifdef FREQ_DISPLAY_LZB_EN
    localparam logic [6:0] HI_ZERO = 7'b1111111;
`else
    localparam logic [6:0] HI_ZERO = 7'b1000000;
`endif

    logic             CLK;
    logic             RST_N;
    logic [CNT_W-1:0] count;
    logic             count_valid;
    logic             busy;
    logic [15:0]      bcd;
    logic             overflow;
    logic [3:0]       an;
    logic [6:0]       seg;

    int n_cmp = 0;
    int n_bad = 0;

    // reference model state
    int          m_n    = 0;
    bit          m_have = 0;
    int          m_k    = 0;
    int          m_val  = 0;
    logic [15:0] m_bcd  = 16'h0000;
    bit          m_ovf  = 0;
    bit          m_busy = 0;
    logic [3:0]  e_an   = 4'b1111;
    logic [6:0]  e_seg  = 7'b1111111;

    freq_display #(.CNT_W(CNT_W), .REFRESH_DIV(DIV)) dut (
        .CLK(CLK), .RST_N(RST_N), .count(count), .count_valid(count_valid),
        .busy(busy), .bcd(bcd), .overflow(overflow), .an(an), .seg(seg)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, req);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        if (v > 9999) return 16'h9999;
        return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    function automatic logic [6:0] segmap(input logic [3:0] d);
        logic [6:0] tbl [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
        if (d > 4'd9) return 7'b1111111;
        return tbl[d];
    endfunction

    function automatic logic [10:0] disp(input int idx, input logic [15:0] b, input bit ov);
        logic [3:0] a;
        logic [6:0] s;
        bit         blk;
        a = 4'b1111;
        a[idx] = 1'b0;
        blk = 0;
`ifdef FREQ_DISPLAY_LZB_EN
        if (idx > 0) begin
            blk = 1;
            for (int j = idx; j < 4; j++) if (b[4*j +: 4] != 4'd0) blk = 0;
        end
`endif
        if (ov) s = 7'b0111111;
        else if (blk) s = 7'b1111111;
        else s = segmap(b[4*idx +: 4]);
        return {a, s};
    endfunction

    // Model advance and output compare, once per clock at the falling edge.
    initial begin
        logic             cv_s;
        logic [CNT_W-1:0] cnt_s;
        logic             rst_s;
        forever begin
            @(posedge CLK);
            cv_s  = count_valid;
            cnt_s = count;
            rst_s = RST_N;
            @(negedge CLK);
            if (!RST_N) begin
                m_n = 0; m_have = 0; m_bcd = 16'h0000; m_ovf = 0; m_busy = 0;
                e_an = 4'b1111; e_seg = 7'b1111111;
            end else if (rst_s) begin
                m_n++;
                {e_an, e_seg} = disp(((m_n - 1) / DIV) % 4, m_bcd, m_ovf);
                if (m_have) begin
                    if (m_n == m_k + CNT_W + 1) begin
                        m_bcd  = to_bcd(m_val);
                        m_ovf  = (m_val > 9999);
                        m_have = 0;
                    end
                end else if (cv_s) begin
                    m_have = 1;
                    m_k    = m_n;
                    m_val  = int'(cnt_s);
                end
                m_busy = m_have;
            end
            check("cmp_busy", busy, m_busy);
            check("cmp_bcd", bcd, m_bcd);
            check("cmp_overflow", overflow, m_ovf);
            check("cmp_an", an, e_an);
            check("cmp_seg", seg, e_seg);
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic strobe(input int v);
        count       = CNT_W'(v);
        count_valid = 1'b1;
        tick();
        count_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int c;
        c = 0;
        while (busy && c < 200) begin
            tick();
            c++;
        end
        check("idle_timeout", busy, 1'b0);
    endtask

    initial begin
        int         c;
        logic [3:0] seen;
        RST_N       = 1'b1;
        count       = '0;
        count_valid = 1'b0;
        #2 RST_N = 1'b0;
        #1;
        check("rst_an", an, 4'b1111);
        check("rst_seg", seg, 7'b1111111);
        check("rst_busy", busy, 1'b0);
        check("rst_bcd", bcd, 16'h0000);
        check("rst_overflow", overflow, 1'b0);
        tick(); tick();
        RST_N = 1'b1;
        tick();
        check("first_an", an, 4'b1110);
        check("first_seg", seg, 7'b1000000);

        // 1234: busy for CNT_W+1 cycles, exact result
        strobe(1234);
        c = 0;
        while (busy && c < 100) begin
            c++;
            tick();
        end
        check("busy_len", c, 15);
        check("lit_1234", bcd, 16'h1234);
        check("lit_1234_ovf", overflow, 1'b0);

        // 10000: saturate with dashes
        strobe(10000);
        wait_idle();
        check("lit_10000", bcd, 16'h9999);
        check("lit_10000_ovf", overflow, 1'b1);
        for (int i = 0; i < 8; i++) begin
            tick();
            check("lit_dash", seg, 7'b0111111);
        end

        // second strobe three cycles into a conversion is dropped
        strobe(1234);
        tick(); tick();
        strobe(5678);
        wait_idle();
        check("lit_ignore", bcd, 16'h1234);
        repeat (20) tick();
        check("lit_ignore_hold", bcd, 16'h1234);
        check("lit_ignore_busy", busy, 1'b0);

        // range ends
        strobe(0);
        wait_idle();
        check("lit_0", bcd, 16'h0000);
        check("lit_0_ovf", overflow, 1'b0);
        strobe(9999);
        wait_idle();
        check("lit_9999", bcd, 16'h9999);
        check("lit_9999_ovf", overflow, 1'b0);

        // 42: full digit scan
        strobe(42);
        wait_idle();
        tick();
        seen = 4'b0000;
        for (int i = 0; i < 20; i++) begin
            tick();
            case (an)
                4'b1110: begin seen[0] = 1'b1; check("lit42_d0", seg, 7'b0100100); end
                4'b1101: begin seen[1] = 1'b1; check("lit42_d1", seg, 7'b0011001); end
                4'b1011: begin seen[2] = 1'b1; check("lit42_d2", seg, HI_ZERO); end
                4'b0111: begin seen[3] = 1'b1; check("lit42_d3", seg, HI_ZERO); end
                default: check("lit42_onehot", an, 4'b1110);
            endcase
        end
        check("lit42_rotation", seen, 4'b1111);

        // reset during the fifth shift aborts the conversion
        RST_N = 1'b0;
        tick(); tick();
        RST_N = 1'b1;
        tick();
        strobe(1234);
        repeat (5) tick();
        RST_N = 1'b0;
        #1;
        check("abort_busy", busy, 1'b0);
        check("abort_bcd", bcd, 16'h0000);
        check("abort_an", an, 4'b1111);
        tick(); tick();
        RST_N = 1'b1;
        repeat (20) tick();
        check("abort_no_update", bcd, 16'h0000);
        check("abort_idle", busy, 1'b0);
        strobe(9);
        wait_idle();
        check("lit_9", bcd, 16'h0009);

        // randomized traffic, including strobes that land while busy
        for (int i = 0; i < 60; i++) begin
            int v;
            case ($urandom % 6)
                0:       v = 0;
                1:       v = 9999;
                2:       v = 10000;
                3:       v = int'($urandom % (1 << CNT_W));
                default: v = int'($urandom % 10000);
            endcase
            strobe(v);
            repeat ($urandom_range(0, 22)) tick();
        end
        wait_idle();
        repeat (20) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
